// File: rtl/xb_upstream_stream_fifo.sv
// xb_upstream_stream_fifo: FPGA->host stream FIFO feeding one Xillybus read-stream port
//   bus_clk, bus_rst_n           : clock, async active-low reset
//   in_data/in_valid/in_last     : producer word, valid, end-of-frame marker
//   in_ready                     : producer handshake
//   user_r_rden/data/empty/eof   : Xillybus read side
//   user_r_open                  : host has the device file open
//   fill_level, drop_count       : stored words, saturating discarded-word count
module xb_upstream_stream_fifo #(
  parameter int DATA_W           = 16,
  parameter int DEPTH_LOG2       = 9,
  parameter bit DROP_WHEN_CLOSED = 1'b1
) (
  input  logic                  bus_clk,
  input  logic                  bus_rst_n,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  user_r_rden,
  output logic [DATA_W-1:0]     user_r_data,
  output logic                  user_r_empty,
  output logic                  user_r_eof,
  input  logic                  user_r_open,
  output logic [DEPTH_LOG2:0]   fill_level,
  output logic [15:0]           drop_count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  typedef enum logic [1:0] {CLOSED, STREAM, EOF} state_t;
  state_t                  state_q, state_d;
  logic                    open_q;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     fill_q, fill_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [15:0]             drop_q, drop_d;
  logic [DATA_W:0]         mem [DEPTH];
  logic [DATA_W:0]         rd_word;
  logic                    full, sink, wr, drop, pop, closing;
  assign full         = fill_q == (DEPTH_LOG2+1)'(DEPTH);
  assign sink         = state_q == CLOSED && DROP_WHEN_CLOSED;
  assign in_ready     = sink || !full;
  assign user_r_empty = fill_q == '0 || state_q != STREAM;
  assign user_r_eof   = state_q == EOF;
  assign user_r_data  = data_q;
  assign fill_level   = fill_q;
  assign drop_count   = drop_q;
  always_comb begin
    wr       = in_valid && in_ready && !sink;
    drop     = in_valid && sink;
    pop      = user_r_rden && !user_r_empty;
    rd_word  = mem[rd_ptr_q];
    closing  = state_q != CLOSED && !open_q;
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(wr);
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
    fill_d   = fill_q + (DEPTH_LOG2+1)'(wr) - (DEPTH_LOG2+1)'(pop);
    data_d   = pop ? rd_word[DATA_W-1:0] : data_q;
    drop_d   = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    state_d  = closing ? CLOSED :
               (state_q == CLOSED && open_q) ? STREAM :
               (state_q == STREAM && pop && rd_word[DATA_W]) ? EOF : state_q;
    // Flushing on close overrides any same-cycle write or pop bookkeeping.
    if (closing && DROP_WHEN_CLOSED) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
    end
  end
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      state_q  <= CLOSED;
      open_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      data_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      open_q   <= user_r_open;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      data_q   <= data_d;
      drop_q   <= drop_d;
    end
  end
  // Storage carries the end-of-frame flag alongside each word.
  always_ff @(posedge bus_clk) begin
    if (wr) mem[wr_ptr_q] <= {in_last, in_data};
  end
endmodule

// File: tb/tb_xb_upstream_stream_fifo.sv
// tb_xb_upstream_stream_fifo: scoreboard bench, instance 0 drops while closed, instance 1 holds
module tb_xb_upstream_stream_fifo;
  localparam int D = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data [2];
  logic        in_valid [2];
  logic        in_last [2];
  logic        in_ready [2];
  logic        rden [2];
  logic [15:0] data [2];
  logic        empty [2];
  logic        eof [2];
  logic        open [2];
  logic [2:0]  fill [2];
  logic [15:0] drops [2];
  int errs = 0;
  int checks = 0;
  xb_upstream_stream_fifo #(.DATA_W(16), .DEPTH_LOG2(2), .DROP_WHEN_CLOSED(1'b1)) u0 (
    .bus_clk(clk), .bus_rst_n(rst_n), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_last(in_last[0]), .in_ready(in_ready[0]), .user_r_rden(rden[0]),
    .user_r_data(data[0]), .user_r_empty(empty[0]), .user_r_eof(eof[0]),
    .user_r_open(open[0]), .fill_level(fill[0]), .drop_count(drops[0]));
  xb_upstream_stream_fifo #(.DATA_W(16), .DEPTH_LOG2(2), .DROP_WHEN_CLOSED(1'b0)) u1 (
    .bus_clk(clk), .bus_rst_n(rst_n), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_last(in_last[1]), .in_ready(in_ready[1]), .user_r_rden(rden[1]),
    .user_r_data(data[1]), .user_r_empty(empty[1]), .user_r_eof(eof[1]),
    .user_r_open(open[1]), .fill_level(fill[1]), .drop_count(drops[1]));
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  task automatic chk(string n, int i, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", n, i, a, e, $time);
    end
  endtask
  // Reference model: a queue of {last,data} per instance plus the open/stream/eof view.
  logic [16:0] mq [2][$];
  int          st [2];
  bit          od [2];
  int          mdrop [2];
  bit          pend [2];
  logic [15:0] nxt [2];
  int          sz;
  bit          drp, mrdy, memp, mwr, mpop;
  logic [16:0] w;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      drp = (i == 0);
      if (!rst_n) begin
        mq[i].delete();
        st[i] = 0;
        od[i] = 1'b0;
        mdrop[i] = 0;
        pend[i] = 1'b0;
      end else begin
        sz   = mq[i].size();
        mrdy = (st[i] == 0 && drp) ? 1'b1 : (sz < D);
        memp = (sz == 0) || (st[i] != 1);
        if (pend[i]) chk("rd_data", i, 32'(data[i]), 32'(nxt[i]));
        chk("fill", i, 32'(fill[i]), 32'(sz));
        chk("empty", i, 32'(empty[i]), 32'(memp));
        chk("eof", i, 32'(eof[i]), 32'(st[i] == 2));
        chk("in_ready", i, 32'(in_ready[i]), 32'(mrdy));
        chk("drops", i, 32'(drops[i]), 32'(mdrop[i]));
        mwr  = in_valid[i] && mrdy;
        mpop = rden[i] && !memp;
        pend[i] = mpop;
        w = '0;
        if (mpop) begin
          w = mq[i].pop_front();
          nxt[i] = w[15:0];
        end
        if (mwr) begin
          if (st[i] == 0 && drp) begin
            if (mdrop[i] < 65535) mdrop[i]++;
          end else mq[i].push_back({in_last[i], in_data[i]});
        end
        if (st[i] != 0 && !od[i]) begin
          st[i] = 0;
          if (drp) mq[i].delete();
        end else if (st[i] == 0 && od[i]) st[i] = 1;
        else if (st[i] == 1 && mpop && w[16]) st[i] = 2;
        od[i] = open[i];
      end
    end
  end
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(int i, logic [15:0] d, logic l);
    bit done = 1'b0;
    in_data[i] = d;
    in_last[i] = l;
    in_valid[i] = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      done = in_ready[i];
      @(posedge clk);
      #1;
    end
    in_valid[i] = 1'b0;
    in_last[i] = 1'b0;
    chk("send_accept", i, 32'(done), 32'd1);
  endtask
  task automatic read(int i, int n);
    rden[i] = 1'b1;
    tick(n);
    rden[i] = 1'b0;
    tick(2);
  endtask
  int sent;
  initial begin
    for (int i = 0; i < 2; i++) begin
      in_data[i] = '0; in_valid[i] = 0; in_last[i] = 0; rden[i] = 0; open[i] = 0;
    end
    tick(3);
    for (int i = 0; i < 2; i++) begin
      chk("rst_fill", i, 32'(fill[i]), 0);
      chk("rst_empty", i, 32'(empty[i]), 1);
      chk("rst_data", i, 32'(data[i]), 0);
    end
    rst_n = 1'b1;
    open[0] = 1'b1;
    open[1] = 1'b1;
    tick(3);
    for (int k = 1; k <= 4; k++) send(0, 16'(k), k == 4);
    read(0, 4);
    chk("t1_data", 0, 32'(data[0]), 4);
    chk("t1_empty", 0, 32'(empty[0]), 1);
    chk("t1_eof", 0, 32'(eof[0]), 1);
    chk("t1_fill", 0, 32'(fill[0]), 0);
    for (int k = 1; k <= 4; k++) send(1, 16'(k), 1'b0);
    chk("t2_full_rdy", 1, 32'(in_ready[1]), 0);
    chk("t2_fill", 1, 32'(fill[1]), 4);
    in_data[1] = 16'd5;
    in_valid[1] = 1'b1;
    tick(3);
    chk("t2_hold_rdy", 1, 32'(in_ready[1]), 0);
    rden[1] = 1'b1;
    tick();
    rden[1] = 1'b0;
    tick();
    in_valid[1] = 1'b0;
    chk("t2_fill_after", 1, 32'(fill[1]), 4);
    read(1, 6);
    open[0] = 1'b0;
    tick(3);
    in_valid[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data[0] = 16'($urandom);
      tick();
    end
    chk("t3_drop10", 0, 32'(drops[0]), 10);
    chk("t3_fill", 0, 32'(fill[0]), 0);
    chk("t3_rdy", 0, 32'(in_ready[0]), 1);
    tick(65530);
    in_valid[0] = 1'b0;
    tick();
    chk("t3_sat", 0, 32'(drops[0]), 32'hFFFF);
    open[0] = 1'b1;
    tick(3);
    for (int k = 0; k < 3; k++) send(0, 16'(16'h100 + k), 1'b0);
    chk("t4_fill3", 0, 32'(fill[0]), 3);
    open[0] = 1'b0;
    tick(2);
    chk("t4_flush", 0, 32'(fill[0]), 0);
    chk("t4_eof", 0, 32'(eof[0]), 0);
    open[0] = 1'b1;
    tick(3);
    chk("t4_reopen_empty", 0, 32'(empty[0]), 1);
    send(1, 16'h10, 1'b0);
    send(1, 16'h11, 1'b0);
    send(1, 16'h12, 1'b1);
    open[1] = 1'b0;
    tick(2);
    chk("t5_keep", 1, 32'(fill[1]), 3);
    send(1, 16'h13, 1'b0);
    in_data[1] = 16'h14;
    in_valid[1] = 1'b1;
    tick(3);
    chk("t5_closed_full", 1, 32'(in_ready[1]), 0);
    in_valid[1] = 1'b0;
    open[1] = 1'b1;
    tick(3);
    read(1, 5);
    chk("t5_eof", 1, 32'(eof[1]), 1);
    chk("t5_behind", 1, 32'(fill[1]), 1);
    open[1] = 1'b0;
    tick(3);
    open[1] = 1'b1;
    tick(3);
    read(1, 2);
    chk("t5_last_word", 1, 32'(data[1]), 32'h13);
    sent = 0;
    for (int k = 0; k < 3000 && sent < 100; k++) begin
      in_valid[0] = $urandom_range(0, 3) != 0;
      in_data[0] = 16'($urandom);
      rden[0] = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid[0] && in_ready[0]) sent++;
      @(posedge clk);
      #1;
    end
    in_valid[0] = 1'b0;
    chk("t6_sent", 0, 32'(sent), 100);
    read(0, 6);
    chk("t6_drained", 0, 32'(fill[0]), 0);
    for (int k = 0; k < 20; k++) begin
      in_valid[0] = 1'($urandom_range(0, 1));
      in_data[0] = 16'($urandom);
      rden[0] = 1'($urandom_range(0, 1));
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("mid_rst_fill", i, 32'(fill[i]), 0);
      chk("mid_rst_empty", i, 32'(empty[i]), 1);
      chk("mid_rst_eof", i, 32'(eof[i]), 0);
      chk("mid_rst_data", i, 32'(data[i]), 0);
      chk("mid_rst_drops", i, 32'(drops[i]), 0);
      chk("mid_rst_rdy", i, 32'(in_ready[i]), 1);
    end
    in_valid[0] = 1'b0;
    rden[0] = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
